// File: rtl/pll_clken_gen.sv
// pll_clken_gen: multi-channel DDS clock-enable generator in the system clock domain.
// Each channel owns a phase accumulator whose carry is a one-cycle enable strobe and whose
// MSB is a square-wave clock. A valid/ready port reprograms one channel at a time and
// re-aligns every channel. locked reports that the last applied configuration has settled.
// Build macro CLKEN_PHASE_EN adds cfg_phase and a per-channel start phase loaded at re-alignment.
module pll_clken_gen #(
  parameter int NUM_CH      = 2,
  parameter int ACC_W       = 16,
  parameter int LOCK_CYCLES = 16,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
`ifdef CLKEN_PHASE_EN
  input  logic [ACC_W-1:0]  cfg_phase,
`endif
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clken,
  output logic [NUM_CH-1:0] outclk,
  output logic              locked
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_APPLY  = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_LOCKED = 2'd3;

  localparam int               CNT_W      = 16;
  localparam logic [CNT_W-1:0] LOCK_CNT_C = CNT_W'(LOCK_CYCLES);

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [CNT_W-1:0]  settle_cnt_r;
  logic              cfg_ready_r;
  logic              cfg_err_r;
  logic              locked_r;
  logic [NUM_CH-1:0] clken_r;
  logic [NUM_CH-1:0] outclk_r;
  logic [CH_W-1:0]   ch_q_r;
  logic [ACC_W-1:0]  inc_q_r;
  logic [ACC_W-1:0]  inc_r      [NUM_CH];
  logic [ACC_W-1:0]  acc_r      [NUM_CH];
  logic [ACC_W-1:0]  inc_new_s  [NUM_CH];
  logic [ACC_W-1:0]  acc_init_s [NUM_CH];
  logic [ACC_W:0]    sum_s      [NUM_CH];
  logic              hs_s;
  logic              ch_bad_s;
  logic              hs_ok_s;
`ifdef CLKEN_PHASE_EN
  logic [ACC_W-1:0]  phase_q_r;
  logic [ACC_W-1:0]  phase_r     [NUM_CH];
  logic [ACC_W-1:0]  phase_new_s [NUM_CH];
`endif

  assign hs_s     = cfg_valid & cfg_ready_r;
  assign ch_bad_s = (int'(cfg_ch) >= NUM_CH);
  assign hs_ok_s  = hs_s & ~ch_bad_s;

  assign cfg_ready = cfg_ready_r;
  assign cfg_err   = cfg_err_r;
  assign clken     = clken_r;
  assign outclk    = outclk_r;
  assign locked    = locked_r;

  // Next-state selection for the configuration sequencer; a bad channel never reaches APPLY.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (hs_ok_s) state_nxt_s = ST_APPLY;
        else         state_nxt_s = ST_IDLE;
      end
      ST_APPLY: begin
        state_nxt_s = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (hs_ok_s)                                   state_nxt_s = ST_APPLY;
        else if ((settle_cnt_r + 16'd1) == LOCK_CNT_C) state_nxt_s = ST_LOCKED;
        else                                           state_nxt_s = ST_SETTLE;
      end
      ST_LOCKED: begin
        if (hs_ok_s) state_nxt_s = ST_APPLY;
        else         state_nxt_s = ST_LOCKED;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, settle counter, request capture and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      settle_cnt_r <= '0;
      cfg_ready_r  <= 1'b0;
      cfg_err_r    <= 1'b0;
      locked_r     <= 1'b0;
      ch_q_r       <= '0;
      inc_q_r      <= '0;
`ifdef CLKEN_PHASE_EN
      phase_q_r    <= '0;
`endif
    end else begin
      state_r     <= state_nxt_s;
      // Ready is low only for the single APPLY cycle, so a held cfg_valid is not re-sampled.
      cfg_ready_r <= (state_nxt_s != ST_APPLY);
      cfg_err_r   <= hs_s & ch_bad_s;
      // Locked survives the accept edge and falls on the APPLY edge itself.
      locked_r    <= (state_r == ST_LOCKED) || (state_nxt_s == ST_LOCKED);
      if (state_r == ST_APPLY)       settle_cnt_r <= '0;
      else if (state_r == ST_SETTLE) settle_cnt_r <= settle_cnt_r + 16'd1;
      else                           settle_cnt_r <= settle_cnt_r;
      if (hs_ok_s) begin
        ch_q_r    <= cfg_ch;
        inc_q_r   <= cfg_inc;
`ifdef CLKEN_PHASE_EN
        phase_q_r <= cfg_phase;
`endif
      end
    end
  end

  // Per-channel settings as they stand after an APPLY, accumulator start values and running sums.
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      inc_new_s[ch]  = inc_r[ch];
      acc_init_s[ch] = '0;
      sum_s[ch]      = {1'b0, acc_r[ch]} + {1'b0, inc_r[ch]};
      if (ch_q_r == CH_W'(ch)) inc_new_s[ch] = inc_q_r;
      else                     inc_new_s[ch] = inc_r[ch];
`ifdef CLKEN_PHASE_EN
      phase_new_s[ch] = phase_r[ch];
      if (ch_q_r == CH_W'(ch)) phase_new_s[ch] = phase_q_r;
      else                     phase_new_s[ch] = phase_r[ch];
      // A disabled channel stays parked at zero rather than at its phase.
      if (inc_new_s[ch] != '0) acc_init_s[ch] = phase_new_s[ch];
      else                     acc_init_s[ch] = '0;
`endif
    end
  end

  // Per-channel increment/phase registers, accumulators and the strobe/square-wave outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        inc_r[ch]   <= '0;
        acc_r[ch]   <= '0;
`ifdef CLKEN_PHASE_EN
        phase_r[ch] <= '0;
`endif
      end
      clken_r  <= '0;
      outclk_r <= '0;
    end else begin
      case (state_r)
        ST_APPLY: begin
          for (int ch = 0; ch < NUM_CH; ch++) begin
            inc_r[ch]   <= inc_new_s[ch];
            acc_r[ch]   <= acc_init_s[ch];
`ifdef CLKEN_PHASE_EN
            phase_r[ch] <= phase_new_s[ch];
`endif
          end
          clken_r  <= '0;
          outclk_r <= '0;
        end
        ST_SETTLE, ST_LOCKED: begin
          for (int ch = 0; ch < NUM_CH; ch++) begin
            acc_r[ch]    <= sum_s[ch][ACC_W-1:0];
            clken_r[ch]  <= sum_s[ch][ACC_W];
            outclk_r[ch] <= sum_s[ch][ACC_W-1];
          end
        end
        default: begin
          for (int ch = 0; ch < NUM_CH; ch++) begin
            acc_r[ch] <= '0;
          end
          clken_r  <= '0;
          outclk_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_clken_gen.sv
// Self-checking bench for pll_clken_gen (NUM_CH=2, ACC_W=8, LOCK_CYCLES=4, CH_W=2 so that
// channel 3 is representable). A closed-form DDS model predicts every output each cycle;
// directed sequences also pin hand-computed strobe patterns.
module tb_pll_clken_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] tb_ch;
  logic [7:0] tb_inc;
`ifdef CLKEN_PHASE_EN
  logic [7:0] tb_phase;
`endif
  logic       cfg_err;
  logic [1:0] clken;
  logic [1:0] outclk;
  logic       locked;

  int n_tests = 0;
  int n_fail  = 0;

  pll_clken_gen #(.NUM_CH(2), .ACC_W(8), .LOCK_CYCLES(4), .CH_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (tb_ch),
    .cfg_inc   (tb_inc),
`ifdef CLKEN_PHASE_EN
    .cfg_phase (tb_phase),
`endif
    .cfg_err   (cfg_err),
    .clken     (clken),
    .outclk    (outclk),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // After an applied configuration, the accumulator of a channel at edge k is
  // base + k*inc; a strobe fires whenever floor(value/256) steps, and the square wave
  // is bit 7 of the value modulo 256.
  bit     m_valid = 1'b0;
  bit     m_ready, m_err, m_locked, m_pend, m_run, m_hs;
  logic [1:0] m_clken, m_outclk;
  int     m_inc[2];
  int     m_phase[2];
  int     m_pch, m_pinc, m_pph;
  longint m_k, m_cur, m_prev, m_base;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 1'b1; m_ready = 1'b0; m_err = 1'b0; m_locked = 1'b0;
      m_clken = 2'b00; m_outclk = 2'b00; m_pend = 1'b0; m_run = 1'b0; m_k = 0;
      for (int c = 0; c < 2; c++) begin m_inc[c] = 0; m_phase[c] = 0; end
    end else if (m_valid) begin
      m_hs = cfg_valid && m_ready;
      if (m_pend) begin
        m_inc[m_pch] = m_pinc; m_phase[m_pch] = m_pph;
        m_k = 0; m_run = 1'b1; m_pend = 1'b0;
        m_clken = 2'b00; m_outclk = 2'b00; m_locked = 1'b0;
      end else if (m_run) begin
        m_k++;
        for (int c = 0; c < 2; c++) begin
          m_base = (m_inc[c] == 0) ? 0 : longint'(m_phase[c]);
          m_cur  = m_base + m_k * m_inc[c];
          m_prev = m_base + (m_k - 1) * m_inc[c];
          m_clken[c]  = ((m_cur / 256) != (m_prev / 256));
          m_outclk[c] = ((m_cur % 256) >= 128);
        end
        m_locked = (m_k >= 4);
      end else begin
        m_clken = 2'b00; m_outclk = 2'b00; m_locked = 1'b0;
      end
      m_err = m_hs && (tb_ch >= 2'd2);
      if (m_hs && (tb_ch < 2'd2)) begin
        m_pend = 1'b1; m_pch = int'(tb_ch); m_pinc = int'(tb_inc);
`ifdef CLKEN_PHASE_EN
        m_pph = int'(tb_phase);
`else
        m_pph = 0;
`endif
      end
      m_ready = !m_pend;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("m_clken",  32'(clken),     32'(m_clken));
      check("m_outclk", 32'(outclk),    32'(m_outclk));
      check("m_locked", 32'(locked),    32'(m_locked));
      check("m_ready",  32'(cfg_ready), 32'(m_ready));
      check("m_err",    32'(cfg_err),   32'(m_err));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic program_ch(input logic [1:0] ch, input logic [7:0] inc);
    cfg_valid = 1'b1; tb_ch = ch; tb_inc = inc;
    tick();
    check("apply_ready_low", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b0;
    tick();
    check("apply_locked_low", 32'(locked), 32'd0);
    check("apply_clken_clr",  32'(clken),  32'd0);
  endtask

  task automatic run_edges(input int n, output logic [31:0] c0, output logic [31:0] c1,
                           output logic [31:0] o0, output logic [31:0] lk);
    c0 = '0; c1 = '0; o0 = '0; lk = '0;
    for (int i = 0; i < n; i++) begin
      tick();
      c0[i] = clken[0]; c1[i] = clken[1]; o0[i] = outclk[0]; lk[i] = locked;
    end
  endtask

  logic [31:0] c0, c1, o0, lk;
  logic [5:0]  rv, lv;
  logic        was_rdy;
  int          idx;
  logic [1:0]  b2b_ch  [3];
  logic [7:0]  b2b_inc [3];

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b1; tb_ch = 2'd0; tb_inc = 8'd0;
`ifdef CLKEN_PHASE_EN
    tb_phase = 8'd0;
`endif
    b2b_ch[0] = 2'd0; b2b_inc[0] = 8'd32;
    b2b_ch[1] = 2'd1; b2b_inc[1] = 8'd16;
    b2b_ch[2] = 2'd0; b2b_inc[2] = 8'd255;

    // Reset held three edges with cfg_valid high.
    repeat (3) tick();
    check("rst_clken",  32'(clken),     32'd0);
    check("rst_outclk", 32'(outclk),    32'd0);
    check("rst_locked", 32'(locked),    32'd0);
    check("rst_ready",  32'(cfg_ready), 32'd0);
    rst_n = 1'b1; cfg_valid = 1'b0;
    tick();
    check("rst_ready_after", 32'(cfg_ready), 32'd1);

    // ch0 inc=64: strobes on edges 4,8,12; square wave high on 2-3, 6-7, 10-11.
    program_ch(2'd0, 8'd64);
    run_edges(12, c0, c1, o0, lk);
    check("t1_clken0",  c0, 32'h888);
    check("t1_clken1",  c1, 32'h000);
    check("t1_outclk0", o0, 32'h666);
    check("t1_locked",  lk, 32'hFF8);

    // ch1 inc=96 while ch0 runs: both re-aligned, ch1 strobes 3,6,8,11,14,16.
    program_ch(2'd1, 8'd96);
    run_edges(16, c0, c1, o0, lk);
    check("t2_clken0", c0, 32'h8888);
    check("t2_clken1", c1, 32'hA4A4);
    check("t2_locked", lk, 32'hFFF8);

    // Out-of-range channel: error pulse only, timing carries on (edges 19..26 since APPLY).
    cfg_valid = 1'b1; tb_ch = 2'd3; tb_inc = 8'd200;
    tick();
    check("t3_err_pulse", 32'(cfg_err),   32'd1);
    check("t3_ready",     32'(cfg_ready), 32'd1);
    check("t3_locked",    32'(locked),    32'd1);
    cfg_valid = 1'b0;
    tick();
    check("t3_err_clear", 32'(cfg_err), 32'd0);
    run_edges(8, c0, c1, o0, lk);
    check("t3_clken0", c0, 32'h22);
    check("t3_clken1", c1, 32'h29);
    check("t3_locked_held", lk, 32'hFF);

    // Back-to-back requests with cfg_valid held: one accept every second cycle.
    idx = 0; cfg_valid = 1'b1; tb_ch = b2b_ch[0]; tb_inc = b2b_inc[0];
    for (int i = 0; i < 6; i++) begin
      was_rdy = cfg_ready;
      tick();
      if (was_rdy && cfg_valid) begin
        idx++;
        if (idx < 3) begin tb_ch = b2b_ch[idx]; tb_inc = b2b_inc[idx]; end
        else cfg_valid = 1'b0;
      end
      rv[i] = cfg_ready; lv[i] = locked;
    end
    check("t4_accepts",   32'(idx), 32'd3);
    check("t4_ready_pat", 32'(rv),  32'h2A);
    check("t4_locked_lo", 32'(lv[5:1]), 32'd0);
    // After the final APPLY: ch0 inc=255 strobes every edge but the first, ch1 inc=16 quiet.
    run_edges(8, c0, c1, o0, lk);
    check("t4_clken0", c0, 32'hFE);
    check("t4_clken1", c1, 32'h00);
    check("t4_locked", lk, 32'hF8);

`ifdef CLKEN_PHASE_EN
    // Programmed phase: ch1 at 128 leads ch0 at 0 by two cycles with inc=64.
    tb_phase = 8'd0;
    program_ch(2'd0, 8'd64);
    tb_phase = 8'd128;
    program_ch(2'd1, 8'd64);
    run_edges(8, c0, c1, o0, lk);
    check("ph_clken0", c0, 32'h88);
    check("ph_clken1", c1, 32'h22);
`endif

    // Reset in the middle of a run clears everything on the next edge.
    rst_n = 1'b0;
    tick();
    check("mr_clken",  32'(clken),     32'd0);
    check("mr_outclk", 32'(outclk),    32'd0);
    check("mr_locked", 32'(locked),    32'd0);
    check("mr_ready",  32'(cfg_ready), 32'd0);
    check("mr_err",    32'(cfg_err),   32'd0);
    rst_n = 1'b1;
    tick();
    check("mr_ready_after", 32'(cfg_ready), 32'd1);
    // Increments were cleared by reset: only ch0 runs; disabled ch1 does not block lock.
    program_ch(2'd0, 8'd64);
    run_edges(4, c0, c1, o0, lk);
    check("mr_clken0", c0, 32'h8);
    check("mr_clken1", c1, 32'h0);
    check("mr_locked", lk, 32'h8);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
